// File: rtl/crc_pkg.sv
// Shared types, bit-order helpers and CRC presets for the streaming CRC engine.
package crc_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } crc_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] poly;
    logic [MAX_W-1:0] init;
    logic [MAX_W-1:0] xorout;
    logic             refl_in;
    logic             refl_out;
    logic [MAX_W-1:0] residue;
    logic [6:0]       width;
  } crc_preset_t;

  localparam crc_preset_t CRC32_ETH = '{
    poly: 64'h04C11DB7, init: 64'hFFFFFFFF, xorout: 64'hFFFFFFFF,
    refl_in: 1'b1, refl_out: 1'b1, residue: 64'hC704DD7B, width: 7'd32};

  localparam crc_preset_t CRC32_MPEG2 = '{
    poly: 64'h04C11DB7, init: 64'hFFFFFFFF, xorout: 64'h0,
    refl_in: 1'b0, refl_out: 1'b0, residue: 64'h0, width: 7'd32};

  localparam crc_preset_t CRC16_CCITT = '{
    poly: 64'h1021, init: 64'hFFFF, xorout: 64'h0,
    refl_in: 1'b0, refl_out: 1'b0, residue: 64'h0, width: 7'd16};

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reverses the low w bits of v; bits above w return zero.
  function automatic logic [MAX_W-1:0] reverse_w(input logic [MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = v[6'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Beat input and result output handshakes of the streaming CRC engine.
interface crc_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;
  logic              out_match;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_crc, out_match
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_crc, out_match
  );
endinterface

// File: rtl/crc_step.sv
// Combinational CRC update over one DATA_W beat, bytes low-first, bits MSB-first.
module crc_step
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W      = 32,
  parameter int unsigned      DATA_W     = 8,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(32'h04C11DB7),
  parameter bit               REFLECT_IN = 1'b1
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next_c
);

  localparam int unsigned N_BYTES = DATA_W / 8;

  logic [CRC_W-1:0] acc;
  logic [7:0]       cur;
  logic             fb;

  always_comb begin
    acc = crc_in;
    cur = '0;
    fb  = 1'b0;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      cur = data[k*8 +: 8];
      if (REFLECT_IN) cur = reflect8(cur);
      for (int i = 7; i >= 0; i--) begin
        fb  = acc[CRC_W-1] ^ cur[i];
        acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
    crc_next_c = acc;
  end

endmodule

// File: rtl/crc_stream.sv
// Framed streaming CRC engine: frame FSM, CRC register, result stage and counters.
module crc_stream
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W       = 32,
  parameter int unsigned      DATA_W      = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(32'h04C11DB7),
  parameter logic [CRC_W-1:0] INIT        = '1,
  parameter logic [CRC_W-1:0] XOROUT      = '1,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE     = CRC_W'(32'hC704DD7B)
) (
  input  logic          clk,
  input  logic          rst,
  crc_stream_if.slave   bus,
  output logic [15:0]   frame_cnt,
  output logic          err_orphan
);

  localparam int unsigned CNT_W = 16;

  crc_state_e       state;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] seed_c;
  logic [CRC_W-1:0] crc_next_c;
  logic [CRC_W-1:0] fin_c;
  logic             accept_c;
  logic             load_c;

  assign bus.in_ready = (state != ST_DONE) || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign seed_c       = bus.in_sop ? INIT : crc_reg;
  // Outside RUN (IDLE, or DONE releasing its result) only a sop beat starts a frame.
  assign load_c       = accept_c && (bus.in_sop || (state == ST_RUN));
  assign fin_c        = (REFLECT_OUT ? CRC_W'(reverse_w(MAX_W'(crc_next_c), CRC_W))
                                     : crc_next_c) ^ XOROUT;

  crc_step #(
    .CRC_W      (CRC_W),
    .DATA_W     (DATA_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_in     (seed_c),
    .data       (bus.in_data),
    .crc_next_c (crc_next_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      crc_reg       <= INIT;
      bus.out_valid <= 1'b0;
      bus.out_crc   <= '0;
      bus.out_match <= 1'b0;
      frame_cnt     <= '0;
      err_orphan    <= 1'b0;
    end else begin
      if ((state == ST_DONE) && bus.out_ready) begin
        state         <= ST_IDLE;
        bus.out_valid <= 1'b0;
        frame_cnt     <= frame_cnt + CNT_W'(1);
      end
      // A load in the same edge as the result handshake overrides the return to IDLE.
      if (load_c) begin
        crc_reg <= crc_next_c;
        if (bus.in_eop) begin
          state         <= ST_DONE;
          bus.out_valid <= 1'b1;
          bus.out_crc   <= fin_c;
          bus.out_match <= (crc_next_c == RESIDUE);
        end else begin
          state <= ST_RUN;
        end
      end else if (accept_c) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// Randomised scoreboard bench for crc_stream: CRC-32 and CRC-16 byte instances plus a 32-bit beat instance.
module tb_crc_stream;
  import crc_pkg::*;

  typedef struct {
    logic [63:0] crc;
    logic        match;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  bit   rand_rdy  = 1'b0;
  bit   fixed_rdy = 1'b1;
  bit   rnd_bit   = 1'b1;

  always #5 clk = ~clk;

  crc_stream_if #(.DATA_W(8),  .CRC_W(32)) a_if ();
  crc_stream_if #(.DATA_W(8),  .CRC_W(16)) c_if ();
  crc_stream_if #(.DATA_W(32), .CRC_W(32)) b_if ();

  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic        a_orph, b_orph, c_orph;

  assign a_if.out_ready = rand_rdy ? rnd_bit : fixed_rdy;
  assign c_if.in_valid  = a_if.in_valid;
  assign c_if.in_data   = a_if.in_data;
  assign c_if.in_sop    = a_if.in_sop;
  assign c_if.in_eop    = a_if.in_eop;
  assign c_if.out_ready = a_if.out_ready;
  assign b_if.out_ready = 1'b1;

  crc_stream dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .frame_cnt(a_cnt), .err_orphan(a_orph));

  crc_stream #(
    .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)
  ) dut_c (
    .clk(clk), .rst(rst), .bus(c_if), .frame_cnt(c_cnt), .err_orphan(c_orph));

  crc_stream #(.DATA_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .frame_cnt(b_cnt), .err_orphan(b_orph));

  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: textbook bytewise CRC, using the right-shifting form for reflected input.
  function automatic logic [63:0] rev(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = v[i];
    return r;
  endfunction

  function automatic void ref_crc(input logic [7:0] msg[$], input int w,
                                  input logic [63:0] poly, input logic [63:0] init,
                                  input logic [63:0] xorout, input bit refin, input bit refout,
                                  output logic [63:0] fin, output logic [63:0] raw);
    logic [63:0] mask;
    logic [63:0] c;
    logic [63:0] rp;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (refin) begin
      rp = rev(poly, w);
      c  = rev(init, w);
      foreach (msg[k]) begin
        c = c ^ 64'(msg[k]);
        repeat (8) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
      end
      raw = rev(c, w);
    end else begin
      c = init & mask;
      foreach (msg[k]) begin
        c = c ^ (64'(msg[k]) << (w - 8));
        repeat (8) c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
      end
      raw = c;
    end
    fin = ((refout ? rev(raw, w) : raw) ^ xorout) & mask;
  endfunction

  task automatic push_ac(input logic [7:0] msg[$]);
    logic [63:0] fin, raw;
    ref_crc(msg, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, fin, raw);
    qa.push_back('{crc: fin, match: (raw == 64'hC704DD7B)});
    ref_crc(msg, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0, fin, raw);
    qc.push_back('{crc: fin, match: (raw == 64'h0)});
  endtask

  task automatic push_b(input logic [7:0] msg[$]);
    logic [63:0] fin, raw;
    ref_crc(msg, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, fin, raw);
    qb.push_back('{crc: fin, match: (raw == 64'hC704DD7B)});
  endtask

  // Drives one byte per beat; entered and left at posedge+1.
  task automatic send_a(input logic [7:0] msg[$], input bit sop, input bit eop);
    int t;
    for (int k = 0; k < msg.size(); k++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = msg[k];
      a_if.in_sop   = sop && (k == 0);
      a_if.in_eop   = eop && (k == msg.size() - 1);
      t = 0;
      @(negedge clk);
      while (!a_if.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeout_fail("a_in_ready_wait");
      @(posedge clk);
      #1;
    end
    a_if.in_valid = 1'b0;
    a_if.in_sop   = 1'b0;
    a_if.in_eop   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] msg[$]);
    int t;
    int nb;
    nb = msg.size() / 4;
    for (int k = 0; k < nb; k++) begin
      b_if.in_valid = 1'b1;
      b_if.in_data  = {msg[4*k+3], msg[4*k+2], msg[4*k+1], msg[4*k]};
      b_if.in_sop   = (k == 0);
      b_if.in_eop   = (k == nb - 1);
      t = 0;
      @(negedge clk);
      while (!b_if.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeout_fail("b_in_ready_wait");
      @(posedge clk);
      #1;
    end
    b_if.in_valid = 1'b0;
    b_if.in_sop   = 1'b0;
    b_if.in_eop   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0 || a_if.out_valid || b_if.out_valid)
           && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) timeout_fail("drain");
  endtask

  // Monitor: every result handshake is compared against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (a_if.out_valid && a_if.out_ready) begin
        if (qa.size() == 0) timeout_fail("a_unexpected_result");
        else begin
          e = qa.pop_front();
          check("a_crc", 64'(a_if.out_crc), e.crc);
          check("a_match", 64'(a_if.out_match), 64'(e.match));
        end
      end
      if (c_if.out_valid && c_if.out_ready) begin
        if (qc.size() == 0) timeout_fail("c_unexpected_result");
        else begin
          e = qc.pop_front();
          check("c_crc", 64'(c_if.out_crc), e.crc);
          check("c_match", 64'(c_if.out_match), 64'(e.match));
        end
      end
      if (b_if.out_valid && b_if.out_ready) begin
        if (qb.size() == 0) timeout_fail("b_unexpected_result");
        else begin
          e = qb.pop_front();
          check("b_crc", 64'(b_if.out_crc), e.crc);
          check("b_match", 64'(b_if.out_match), 64'(e.match));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  vec[$];
    logic [7:0]  m[$];
    logic [7:0]  m2[$];
    logic [63:0] fin, raw;
    int          exp_cnt;
    int          idx;

    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sop = 1'b0; a_if.in_eop = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sop = 1'b0; b_if.in_eop = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(a_if.in_ready), 64'd1);
    check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_out_crc", 64'(a_if.out_crc), 64'd0);
    check("rst_out_match", 64'(a_if.out_match), 64'd0);
    check("rst_frame_cnt", 64'(a_cnt), 64'd0);
    check("rst_err_orphan", 64'(a_orph), 64'd0);
    check("rst_b_in_ready", 64'(b_if.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Check vectors "123456789"
    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    qa.push_back('{crc: 64'hCBF43926, match: 1'b0});
    qc.push_back('{crc: 64'h29B1, match: 1'b0});
    send_a(vec, 1'b1, 1'b1);
    check("latency_out_valid", 64'(a_if.out_valid), 64'd1);
    @(posedge clk);
    #1;
    check("frame_cnt_first", 64'(a_cnt), 64'd1);
    check("c_frame_cnt_first", 64'(c_cnt), 64'd1);
    exp_cnt = 1;
    ref_crc(vec, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'h0, 1'b0, 1'b0, fin, raw);
    check("model_mpeg2_vector", fin, 64'h0376E6E7);

    // Appended CRC gives the residue; corrupted copies must not
    m2 = vec;
    m2.push_back(8'h26); m2.push_back(8'h39); m2.push_back(8'hF4); m2.push_back(8'hCB);
    qa.push_back('{crc: 64'h2144DF1C, match: 1'b1});
    ref_crc(m2, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0, fin, raw);
    qc.push_back('{crc: fin, match: (raw == 64'h0)});
    send_a(m2, 1'b1, 1'b1);
    exp_cnt++;
    for (int r = 0; r < 3; r++) begin
      m = m2;
      idx = $urandom_range(0, m.size() - 1);
      m[idx] = m[idx] ^ 8'($urandom_range(1, 255));
      push_ac(m);
      qa[qa.size()-1].match = 1'b0;
      send_a(m, 1'b1, 1'b1);
      exp_cnt++;
    end
    drain();

    // Backpressure, then release together with a new sop beat
    fixed_rdy = 1'b0;
    push_ac(vec);
    send_a(vec, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(a_if.out_valid), 64'd1);
      check("bp_in_ready", 64'(a_if.in_ready), 64'd0);
      check("bp_out_crc", 64'(a_if.out_crc), 64'hCBF43926);
    end
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    m.delete();
    repeat (5) m.push_back(8'($urandom));
    push_ac(m);
    send_a(m, 1'b1, 1'b1);
    exp_cnt += 2;
    drain();
    check("bp_frame_cnt", 64'(a_cnt), 64'(exp_cnt));

    // Random frames with random result backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 25; f++) begin
      m.delete();
      repeat ($urandom_range(1, 10)) m.push_back(8'($urandom));
      push_ac(m);
      send_a(m, 1'b1, 1'b1);
      exp_cnt++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_rdy = 1'b0;
    check("rand_frame_cnt", 64'(a_cnt), 64'(exp_cnt));
    check("rand_c_frame_cnt", 64'(c_cnt), 64'(exp_cnt));

    // sop in RUN aborts the open frame
    m.delete();
    repeat (4) m.push_back(8'($urandom));
    send_a(m, 1'b1, 1'b0);
    m.delete();
    repeat (3) m.push_back(8'($urandom));
    push_ac(m);
    send_a(m, 1'b1, 1'b1);
    exp_cnt++;
    drain();
    check("abort_frame_cnt", 64'(a_cnt), 64'(exp_cnt));

    // Orphan beat in IDLE
    check("orphan_before", 64'(a_orph), 64'd0);
    m = '{8'hAA};
    send_a(m, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("orphan_after", 64'(a_orph), 64'd1);
    check("orphan_frame_cnt", 64'(a_cnt), 64'(exp_cnt));

    // 32-bit beats: "123456789" plus three random bytes, then random frames
    m = vec;
    repeat (3) m.push_back(8'($urandom));
    push_b(m);
    send_b(m);
    for (int f = 0; f < 4; f++) begin
      m.delete();
      repeat (4 * $urandom_range(1, 4)) m.push_back(8'($urandom));
      push_b(m);
      send_b(m);
    end
    drain();
    check("b_frame_cnt", 64'(b_cnt), 64'd5);

    // Reset while a finished result is held discards it
    fixed_rdy = 1'b0;
    send_a(vec, 1'b1, 1'b1);
    check("pre_rst_out_valid", 64'(a_if.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_mid_frame_cnt", 64'(a_cnt), 64'd0);
    check("rst_mid_err_orphan", 64'(a_orph), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fixed_rdy = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_out_valid", 64'(a_if.out_valid), 64'd0);

    // Counter wrap: 65535 back-to-back single-beat frames, then one more
    for (int f = 0; f < 65535; f++) begin
      m = '{8'($urandom)};
      push_ac(m);
      send_a(m, 1'b1, 1'b1);
    end
    drain();
    check("wrap_ffff", 64'(a_cnt), 64'hFFFF);
    m = '{8'h5A};
    push_ac(m);
    send_a(m, 1'b1, 1'b1);
    drain();
    check("wrap_zero", 64'(a_cnt), 64'd0);
    check("wrap_c_zero", 64'(c_cnt), 64'd0);

    check("qa_empty", 64'(qa.size()), 64'd0);
    check("qc_empty", 64'(qc.size()), 64'd0);
    check("qb_empty", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine and the generalised successor of the fixed CRC-32 byte datapath. It accepts framed data beats over a valid/ready handshake and processes one DATA_W-bit beat per cycle. At end of frame it presents the finished CRC plus a residue-check flag on a second valid/ready port. The block sits between packet-framing logic and MAC/checker logic, and one instance is configured per protocol (Ethernet CRC-32, MPEG-2, CRC-16, ...).

## Interface
- CRC_W, 32, CRC width (8..64)
- DATA_W, 8, beat width in bits (multiple of 8, 8..64)
- POLY, 32'h04C11DB7, generator polynomial, normal form, implicit x^CRC_W
- INIT, all ones, register value loaded at start of frame
- XOROUT, all ones, XOR applied to the final register
- REFLECT_IN, 1, bit-reverse each byte of in_data before shifting
- REFLECT_OUT, 1, bit-reverse the whole register before XOROUT
- RESIDUE, 32'hC704DD7B, raw register value signalling a good frame (CRC appended)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  DATA_W  beat; byte 0 = bits [7:0], processed first
- in_sop  input  1  first beat of frame
- in_eop  input  1  last beat of frame
- out_valid  output  1  result available
- out_ready  input  1  result consumed when out_valid && out_ready
- out_crc  output  CRC_W  final CRC (reflected/XORed per parameters)
- out_match  output  1  raw register == RESIDUE
- frame_cnt  output  16  completed frames, wraps
- err_orphan  output  1  sticky: beat received in IDLE without in_sop

## Operation
- States: IDLE, RUN, DONE.
- IDLE: a beat with in_sop loads INIT and processes the beat in the same cycle. The result goes to RUN, or to DONE if in_eop is also set. A beat without sop is dropped and sets err_orphan.
- RUN: each accepted beat updates the register. in_eop moves to DONE. in_sop in RUN aborts the current frame: the register reloads from INIT, the new beat is processed, and no result is emitted for the aborted frame.
- DONE: out_valid=1. out_crc = (REFLECT_OUT ? reverse(reg) : reg) ^ XOROUT. out_match compares the raw register. Both are held stable until the handshake completes.
- Handshake completion returns to IDLE and increments frame_cnt (16-bit, FFFF→0000).
- Per bit, MSB-first shift-left: fb = reg[CRC_W-1] ^ d; reg = (reg<<1) ^ (fb ? POLY : 0). The CRC_W-bit width is truncated.
- err_orphan is cleared only by rst.

## Timing
- Reset values: in_ready=1, out_valid=0, out_crc=0, out_match=0, frame_cnt=0, err_orphan=0, state IDLE, register=INIT.
- Throughput is one beat per cycle. in_ready = (state != DONE) || out_ready, which allows a zero-bubble back-to-back frame.
- Latency: the eop beat accepted in cycle N gives out_valid=1 in cycle N+1.
- A simultaneous result handshake and new sop beat in DONE emits the old result, then loads INIT and starts the new frame in the same edge.
- A single-beat frame (sop && eop) is legal.
- rst asserted mid-frame or in DONE discards everything immediately (asynchronous). No result is emitted.

## Structure
- Package crc_pkg holds:
  - the state enum;
  - function reflect8 (byte bit-reverse);
  - a generic reverse function for CRC_W;
  - constants for common presets (CRC32_ETH, CRC32_MPEG2, CRC16_CCITT), each bundling POLY/INIT/XOROUT/REFLECT/RESIDUE.
- Sub-module crc_step: purely combinational, computes next register from (reg, data) with DATA_W bits unrolled, parametrised by CRC_W/DATA_W/POLY/REFLECT_IN.
- The top level holds the FSM, register, output stage and counters.

## Test plan
- Defaults, "123456789" as 9 single-byte beats, sop on first, eop on last, out_ready=1 -> out_crc=32'hCBF43926, out_valid one cycle after eop, frame_cnt=1.
- Same message followed by bytes 26 39 F4 CB (appended CRC) -> out_match=1. Corrupting any byte -> out_match=0.
- REFLECT_IN=0, REFLECT_OUT=0, XOROUT=0 with "123456789" -> 32'h0376E6E7. CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, no reflect, XOROUT=0 -> 16'h29B1.
- DATA_W=32, "123456789" padded as 3 beats with the last beat carrying "9"+3 bytes of a second test vector matched against a bytewise reference model -> identical result to the DATA_W=8 instance.
- Backpressure: out_ready held 0 for 5 cycles after eop -> in_ready=0, out_crc stable. Releasing out_ready with a new sop beat in the same cycle -> both frames correct, no lost beat.
- Corner cases:
  - sop in RUN -> first frame discarded, frame_cnt increments once.
  - Beat without sop in IDLE -> err_orphan=1.
  - rst pulse mid-frame -> out_valid=0, frame_cnt=0.
  - 65536 frames -> frame_cnt wraps to 0.
